// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman host-side blocks: Q2.14 format constants,
// sequencer state encodings and a saturating counter helper.
package kalman_pkg;

   localparam int Q_W    = 16;
   localparam int Q_FRAC = 14;

   localparam logic signed [Q_W-1:0] ONE = 16'sd16384;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;
   localparam logic [2:0] ST_OUTPUT  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_START   = ST_START,
      S_WAIT    = ST_WAIT,
      S_CAPTURE = ST_CAPTURE,
      S_RECOVER = ST_RECOVER,
      S_OUTPUT  = ST_OUTPUT
   } state_t;

   function automatic logic [7:0] satInc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/kalman_wdog.sv
// Loadable cycle counter with clear, enable and a run-time selectable expiry
// limit; used as the core watchdog and as the recovery-pulse timer.
module kalman_wdog #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_clear,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_enable,
   input  logic [CW-1:0] i_limit,
   output logic          o_expire
);

   logic [CW-1:0] r_count;

   // Clear has priority over load, load over counting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_enable && (r_count == i_limit);

endmodule

// File: rtl/kalman_initiator.sv
// Host-side sequencer for the Kalman core: hands one measurement to the core,
// waits for its finish edge (or a watchdog timeout) and returns the estimate.
module kalman_initiator
   import kalman_pkg::*;
#(
   parameter int W           = Q_W,
   parameter int TIMEOUT_CYC = 256,
   parameter int RST_CYC     = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         meas_valid,
   output logic         meas_ready,
   input  logic [W-1:0] meas_theta,
   input  logic [W-1:0] meas_phi,
   input  logic         meas_u,
   output logic [W-1:0] core_theta_acc,
   output logic [W-1:0] core_phi_acc,
   output logic         core_u,
   output logic         core_start,
   output logic         core_reset,
   input  logic         core_finish,
   input  logic [W-1:0] core_phi_est,
   input  logic [W-1:0] core_theta_est,
   output logic         est_valid,
   input  logic         est_ready,
   output logic [W-1:0] est_phi,
   output logic [W-1:0] est_theta,
   output logic         est_timeout,
   output logic [7:0]   err_cnt,
   output logic         busy
);

   localparam int MAX_CYC = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] RST_LIM = CW'(RST_CYC - 1);

   state_t         r_state;
   logic           r_meas_ready;
   logic [W-1:0]   r_core_theta;
   logic [W-1:0]   r_core_phi;
   logic           r_core_u;
   logic           r_core_start;
   logic           r_core_reset;
   logic           r_finish_q;
   logic           r_est_valid;
   logic [W-1:0]   r_est_phi;
   logic [W-1:0]   r_est_theta;
   logic           r_est_timeout;
   logic [W-1:0]   r_last_phi;
   logic [W-1:0]   r_last_theta;
   logic [7:0]     r_err_cnt;
   logic           r_busy;

   logic           w_accept;
   logic           w_finish_rise;
   logic           w_wd_clear;
   logic           w_wd_enable;
   logic [CW-1:0]  w_wd_limit;
   logic           w_wd_expire;

   assign w_accept      = meas_valid && r_meas_ready;
   assign w_finish_rise = core_finish && !r_finish_q;

   // One counter serves both phases: restarted entering WAIT and again entering RECOVER.
   assign w_wd_clear  = (r_state == S_START) ||
                        ((r_state == S_WAIT) && !w_finish_rise && w_wd_expire);
   assign w_wd_enable = (r_state == S_WAIT) || (r_state == S_RECOVER);
   assign w_wd_limit  = (r_state == S_RECOVER) ? RST_LIM : TMO_LIM;

   kalman_wdog #(
      .CW(CW)
   ) u_wdog (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clear    (w_wd_clear),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_enable   (w_wd_enable),
      .i_limit    (w_wd_limit),
      .o_expire   (w_wd_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_meas_ready  <= 1'b1;
         r_core_theta  <= '0;
         r_core_phi    <= '0;
         r_core_u      <= 1'b0;
         r_core_start  <= 1'b0;
         r_core_reset  <= 1'b0;
         r_finish_q    <= 1'b0;
         r_est_valid   <= 1'b0;
         r_est_phi     <= '0;
         r_est_theta   <= '0;
         r_est_timeout <= 1'b0;
         r_last_phi    <= '0;
         r_last_theta  <= '0;
         r_err_cnt     <= 8'd0;
         r_busy        <= 1'b0;
      end else begin
         r_finish_q <= core_finish;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_core_theta <= meas_theta;
                  r_core_phi   <= meas_phi;
                  r_core_u     <= meas_u;
                  r_core_start <= 1'b1;
                  r_meas_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_START;
               end
            end
            S_START: begin
               r_core_start <= 1'b0;
               r_state      <= S_WAIT;
            end
            // A finish edge on the expiry cycle still counts as a normal completion.
            S_WAIT: begin
               if (w_finish_rise) begin
                  r_state <= S_CAPTURE;
               end else if (w_wd_expire) begin
                  r_core_reset  <= 1'b1;
                  r_err_cnt     <= satInc8(r_err_cnt);
                  r_est_phi     <= r_last_phi;
                  r_est_theta   <= r_last_theta;
                  r_est_timeout <= 1'b1;
                  r_state       <= S_RECOVER;
               end
            end
            S_CAPTURE: begin
               r_est_phi     <= core_phi_est;
               r_est_theta   <= core_theta_est;
               r_last_phi    <= core_phi_est;
               r_last_theta  <= core_theta_est;
               r_est_timeout <= 1'b0;
               r_est_valid   <= 1'b1;
               r_state       <= S_OUTPUT;
            end
            S_RECOVER: begin
               if (w_wd_expire) begin
                  r_core_reset <= 1'b0;
                  r_est_valid  <= 1'b1;
                  r_state      <= S_OUTPUT;
               end
            end
            S_OUTPUT: begin
               if (est_ready) begin
                  r_est_valid  <= 1'b0;
                  r_busy       <= 1'b0;
                  r_meas_ready <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_core_start <= 1'b0;
               r_core_reset <= 1'b0;
               r_est_valid  <= 1'b0;
               r_busy       <= 1'b0;
               r_meas_ready <= 1'b1;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign meas_ready     = r_meas_ready;
   assign core_theta_acc = r_core_theta;
   assign core_phi_acc   = r_core_phi;
   assign core_u         = r_core_u;
   assign core_start     = r_core_start;
   assign core_reset     = r_core_reset;
   assign est_valid      = r_est_valid;
   assign est_phi        = r_est_phi;
   assign est_theta      = r_est_theta;
   assign est_timeout    = r_est_timeout;
   assign err_cnt        = r_err_cnt;
   assign busy           = r_busy;

endmodule

// File: tb/tb_kalman_initiator.sv
// Randomized scoreboard bench for kalman_initiator with a behavioural stub core.
module tb_kalman_initiator;

   localparam int W   = 16;
   localparam int TMO = 64;
   localparam int RST = 2;

   logic                clk;
   logic                reset_n;
   logic                meas_valid;
   logic                meas_ready;
   logic signed [W-1:0] meas_theta;
   logic signed [W-1:0] meas_phi;
   logic                meas_u;
   logic [W-1:0]        core_theta_acc;
   logic [W-1:0]        core_phi_acc;
   logic                core_u;
   logic                core_start;
   logic                core_reset;
   logic                core_finish;
   logic [W-1:0]        core_phi_est;
   logic [W-1:0]        core_theta_est;
   logic                est_valid;
   logic                est_ready;
   logic [W-1:0]        est_phi;
   logic [W-1:0]        est_theta;
   logic                est_timeout;
   logic [7:0]          err_cnt;
   logic                busy;

   kalman_initiator #(
      .W(W), .TIMEOUT_CYC(TMO), .RST_CYC(RST)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .meas_valid(meas_valid), .meas_ready(meas_ready),
      .meas_theta(meas_theta), .meas_phi(meas_phi), .meas_u(meas_u),
      .core_theta_acc(core_theta_acc), .core_phi_acc(core_phi_acc), .core_u(core_u),
      .core_start(core_start), .core_reset(core_reset), .core_finish(core_finish),
      .core_phi_est(core_phi_est), .core_theta_est(core_theta_est),
      .est_valid(est_valid), .est_ready(est_ready),
      .est_phi(est_phi), .est_theta(est_theta), .est_timeout(est_timeout),
      .err_cnt(err_cnt), .busy(busy)
   );

   typedef struct {
      logic signed [W-1:0] phi;
      logic signed [W-1:0] theta;
      logic                to;
      int                  err;
      int                  lat;
      int                  rstc;
      logic signed [W-1:0] thAcc;
      logic signed [W-1:0] phAcc;
      logic                u;
   } expItem;

   expItem              expQ[$];
   int                  nTests = 0;
   int                  nFail  = 0;
   int                  cyc    = 0;

   // Reference model state: what the sequencer should remember between transactions.
   int                  mErr       = 0;
   logic signed [W-1:0] mLastPhi   = '0;
   logic signed [W-1:0] mLastTheta = '0;

   // Stub core behaviour for the current transaction: finish drops cnt==stubL, rises cnt==stubD (0 = never).
   int                  stubD = 0;
   int                  stubL = 0;
   logic signed [W-1:0] stubPhi = '0;
   logic signed [W-1:0] stubTheta = '0;

   logic                bpReq = 1'b0;
   int                  bpCnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] expv);
      nTests++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Stub core: reacts to start/reset one step after each rising edge.
   initial begin
      int  cnt;
      bit  armed;
      cnt = 0;
      armed = 1'b0;
      core_finish = 1'b0;
      core_phi_est = '0;
      core_theta_est = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n || core_reset) begin
            armed = 1'b0;
            core_finish = 1'b0;
         end else if (core_start) begin
            armed = 1'b1;
            cnt = 0;
            core_phi_est = W'($urandom);
            core_theta_est = W'($urandom);
            if (stubL == 0) core_finish = 1'b0;
         end else if (armed) begin
            cnt++;
            if (cnt == stubL) core_finish = 1'b0;
            if (stubD != 0 && cnt == stubD) begin
               core_finish = 1'b1;
               core_phi_est = stubPhi;
               core_theta_est = stubTheta;
               armed = 1'b0;
            end
         end
      end
   end

   // Result consumer: random readiness, or a forced 20-cycle stall when requested.
   initial begin
      est_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bpReq && est_valid && bpCnt < 20) begin
            est_ready = 1'b0;
            bpCnt++;
            if (bpCnt == 20) bpReq = 1'b0;
         end else begin
            est_ready = ($urandom_range(3, 0) != 0);
         end
      end
   end

   // Monitor: pops the scoreboard whenever a new result is presented.
   initial begin
      expItem              e;
      int                  starts;
      int                  rstc;
      int                  startCyc;
      bit                  prevValid;
      bit                  expectIdle;
      logic [2*W:0]        held;
      starts = 0; rstc = 0; startCyc = 0; prevValid = 0; expectIdle = 0; held = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            starts = 0; rstc = 0; prevValid = 0; expectIdle = 0;
         end else begin
            if (expectIdle) begin
               checkOutput("idle_est_valid", est_valid, 0);
               checkOutput("idle_meas_ready", meas_ready, 1);
               expectIdle = 0;
            end
            if (core_start) begin
               starts++;
               startCyc = cyc;
            end
            if (core_reset) rstc++;
            if (est_valid && !prevValid) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_est_valid", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("est_phi", $signed(est_phi), e.phi);
                  checkOutput("est_theta", $signed(est_theta), e.theta);
                  checkOutput("est_timeout", est_timeout, e.to);
                  checkOutput("err_cnt", err_cnt, e.err);
                  checkOutput("latency", cyc - startCyc, e.lat);
                  checkOutput("start_pulses", starts, 1);
                  checkOutput("core_reset_cycles", rstc, e.rstc);
                  checkOutput("core_theta_acc", $signed(core_theta_acc), e.thAcc);
                  checkOutput("core_phi_acc", $signed(core_phi_acc), e.phAcc);
                  checkOutput("core_u", core_u, e.u);
                  checkOutput("meas_ready_busy", meas_ready, 0);
                  checkOutput("busy_out", busy, 1);
               end
               held = {est_phi, est_theta, est_timeout};
            end else if (est_valid) begin
               checkOutput("est_stable", {est_phi, est_theta, est_timeout}, held);
            end
            if (est_valid && est_ready) begin
               expectIdle = 1;
               starts = 0;
               rstc = 0;
            end
            prevValid = est_valid;
         end
      end
   end

   task automatic applyStimulus(input logic signed [W-1:0] th, input logic signed [W-1:0] ph,
                                input logic u, input int d, input int l,
                                input logic signed [W-1:0] rPhi, input logic signed [W-1:0] rTheta);
      expItem e;
      int     waited;
      waited = 0;
      @(posedge clk);
      #1;
      while (!meas_ready && waited < 5000) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!meas_ready) begin
         checkOutput("meas_ready_wait", meas_ready, 1);
         return;
      end
      stubD = d;
      stubL = l;
      stubPhi = rPhi;
      stubTheta = rTheta;
      meas_theta = th;
      meas_phi = ph;
      meas_u = u;
      meas_valid = 1'b1;
      @(posedge clk);
      #1;
      meas_valid = 1'b0;
      meas_theta = W'($urandom);
      meas_phi = W'($urandom);
      meas_u = 1'($urandom);
      e.thAcc = th;
      e.phAcc = ph;
      e.u = u;
      if (d != 0 && d <= TMO) begin
         mLastPhi = rPhi;
         mLastTheta = rTheta;
         e.to = 1'b0;
         e.lat = d + 2;
         e.rstc = 0;
      end else begin
         mErr = (mErr < 255) ? mErr + 1 : 255;
         e.to = 1'b1;
         e.lat = TMO + 1 + RST;
         e.rstc = RST;
      end
      e.phi = mLastPhi;
      e.theta = mLastTheta;
      e.err = mErr;
      expQ.push_back(e);
   endtask

   task automatic randomTxn(input int d, input int l);
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), d, l, W'($urandom), W'($urandom));
   endtask

   initial begin
      int d;
      int waited;
      reset_n = 1'b0;
      meas_valid = 1'b0;
      meas_theta = '0;
      meas_phi = '0;
      meas_u = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_meas_ready", meas_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_est_valid", est_valid, 0);
      checkOutput("rst_core_start", core_start, 0);
      checkOutput("rst_core_reset", core_reset, 0);
      checkOutput("rst_err_cnt", err_cnt, 0);
      checkOutput("rst_est_data", {est_phi, est_theta, est_timeout}, 0);
      checkOutput("rst_core_data", {core_theta_acc, core_phi_acc, core_u}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      applyStimulus(16'sd491, -16'sd1638, 1'b1, 10, 0, 16'sd100, 16'sd200);
      bpCnt = 0;
      bpReq = 1'b1;
      randomTxn(5, 0);
      randomTxn(0, 0);
      // Finish left high by a capture, then never toggled: must time out.
      randomTxn(7, 0);
      randomTxn(0, -1);
      randomTxn(4, 0);
      randomTxn(15, 6);
      randomTxn(TMO, 0);
      randomTxn(TMO + 1, 0);
      randomTxn(1, 0);

      randomTxn(0, 0);
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      void'(expQ.pop_back());
      mErr = 0;
      mLastPhi = '0;
      mLastTheta = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_meas_ready", meas_ready, 1);
      checkOutput("midrst_est_valid", est_valid, 0);
      checkOutput("midrst_err_cnt", err_cnt, 0);
      checkOutput("midrst_busy", busy, 0);
      repeat (20) @(posedge clk);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(9, 0))
            0:       d = 0;
            1:       d = TMO + int'($urandom_range(2, 0));
            default: d = int'($urandom_range(20, 1));
         endcase
         randomTxn(d, (d == 0) ? -1 : int'($urandom_range(d - 1, 0)));
      end
      randomTxn(9, 0);
      for (int i = 0; i < 300; i++) randomTxn(0, 0);
      randomTxn(3, 0);

      waited = 0;
      while ((expQ.size() != 0 || !meas_ready) && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drain_queue", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
